mem_access_ctrl: RTL and testbench

Sequencer and arbiter for the 256x16 single-port display RAM. It owns the RAM address, write-enable and write-data lines, and serves four requesters in a fixed priority order: block fill, single write, manual address step, and timed auto-scan. It sits between the one-shot conditioned panel controls and the RAM. It replaces the direct wiring of the step one-shot into the address sequencer and of the write one-shot into the RAM.

---
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Display RAM sequencer: arbitrates fill, write, step and auto-scan
// requests and drives the registered RAM address/write lines.
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DWELL  = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              step_req,
    input  logic              wr_req,
    input  logic              fill_req,
    input  logic              scan_en,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] wdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL
    } state_t;

    localparam logic [9:0]        DWELL_LAST = 10'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   saved_q, saved_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic [9:0]          cnt_q, cnt_d;

    logic                scan_wrap;

    assign scan_wrap = scan_en && tick && (cnt_q == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            saved_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            saved_q <= saved_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d = FILL;
                end else if (wr_req) begin
                    state_d = WRITE;
                end
            end
            WRITE: state_d = IDLE;
            FILL: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        saved_d = saved_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    wdata_d = din;
                    saved_d = addr_q;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else if (wr_req) begin
                    wdata_d = din;
                    we_d    = 1'b1;
                end else if (step_req) begin
                    // A coincident scan tick is absorbed by this step
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = '0;
                end else if (!scan_en) begin
                    cnt_d = '0;
                end else if (scan_wrap) begin
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            WRITE: begin
                if (!scan_en) begin
                    cnt_d = '0;
                end
            end
            FILL: begin
                cnt_d = '0;
                if (addr_q == ADDR_LAST) begin
                    addr_d = saved_q;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                addr_d = '0;
            end
        endcase
    end

    assign addr  = addr_q;
    assign we    = we_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: step, write, fill, scan, reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        step_req;
    logic        wr_req;
    logic        fill_req;
    logic        scan_en;
    logic [15:0] din;
    logic [7:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W(8),
        .DATA_W(16),
        .DWELL (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .step_req(step_req),
        .wr_req  (wr_req),
        .fill_req(fill_req),
        .scan_en (scan_en),
        .din     (din),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .busy    (busy)
    );

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic idle_state(input string tag, input logic [7:0] a,
                              input logic [15:0] d);
        chk({tag, ".addr"}, 32'(addr), 32'(a));
        chk({tag, ".we"}, 32'(we), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".wdata"}, 32'(wdata), 32'(d));
    endtask

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        step_req = 1'b0;
        wr_req   = 1'b0;
        fill_req = 1'b0;
        scan_en  = 1'b0;
        din      = 16'h0000;
        cyc(2);
        rst = 1'b0;
        idle_state("reset", 8'd0, 16'h0000);

        for (int i = 1; i <= 3; i++) begin
            step_req = 1'b1;
            cyc();
            step_req = 1'b0;
            chk($sformatf("step%0d.addr", i), 32'(addr), 32'(i));
            chk($sformatf("step%0d.we", i), 32'(we), 32'd0);
            cyc(3);
        end

        step_req = 1'b1;
        cyc(252);
        step_req = 1'b0;
        chk("step_to_255", 32'(addr), 32'd255);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        chk("step_wrap", 32'(addr), 32'd0);

        step_req = 1'b1;
        cyc(5);
        step_req = 1'b0;
        chk("step_to_5", 32'(addr), 32'd5);

        din      = 16'hBEEF;
        wr_req   = 1'b1;
        step_req = 1'b1;
        cyc();
        wr_req   = 1'b0;
        step_req = 1'b0;
        chk("wr.we", 32'(we), 32'd1);
        chk("wr.addr", 32'(addr), 32'd5);
        chk("wr.wdata", 32'(wdata), 32'hBEEF);
        cyc();
        idle_state("wr_done", 8'd5, 16'hBEEF);

        step_req = 1'b1;
        cyc(13);
        step_req = 1'b0;
        chk("step_to_12h", 32'(addr), 32'h12);

        din      = 16'h00A5;
        fill_req = 1'b1;
        cyc();
        fill_req = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("fill%0d.addr", i), 32'(addr), 32'(i));
            chk($sformatf("fill%0d.we", i), 32'(we), 32'd1);
            chk($sformatf("fill%0d.busy", i), 32'(busy), 32'd1);
            chk($sformatf("fill%0d.wdata", i), 32'(wdata), 32'h00A5);
            if (i == 10) begin
                din      = 16'hFFFF;
                wr_req   = 1'b1;
                step_req = 1'b1;
            end else begin
                din      = 16'h00A5;
                wr_req   = 1'b0;
                step_req = 1'b0;
            end
            cyc();
        end
        idle_state("fill_restore", 8'h12, 16'h00A5);

        scan_en = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            pulse_tick();
            chk($sformatf("scan_t%0d", t), 32'(addr),
                (t == 3) ? 32'h13 : 32'h12);
            cyc(9);
        end
        pulse_tick();
        cyc(9);
        pulse_tick();
        chk("scan_pre_drop", 32'(addr), 32'h13);
        cyc(2);
        scan_en = 1'b0;
        cyc(5);
        scan_en = 1'b1;
        cyc(2);
        for (int t = 1; t <= 3; t++) begin
            pulse_tick();
            chk($sformatf("rescan_t%0d", t), 32'(addr),
                (t == 3) ? 32'h14 : 32'h13);
            cyc(9);
        end

        pulse_tick();
        cyc(9);
        pulse_tick();
        cyc(9);
        step_req = 1'b1;
        tick     = 1'b1;
        cyc();
        step_req = 1'b0;
        tick     = 1'b0;
        chk("step_tick_once", 32'(addr), 32'h15);
        cyc(9);
        for (int t = 1; t <= 3; t++) begin
            pulse_tick();
            chk($sformatf("post_step_t%0d", t), 32'(addr),
                (t == 3) ? 32'h16 : 32'h15);
            cyc(9);
        end
        scan_en = 1'b0;

        din      = 16'h1234;
        fill_req = 1'b1;
        cyc();
        fill_req = 1'b0;
        cyc(100);
        chk("fill_mid.addr", 32'(addr), 32'd100);
        chk("fill_mid.busy", 32'(busy), 32'd1);
        rst      = 1'b1;
        fill_req = 1'b1;
        cyc();
        rst      = 1'b0;
        fill_req = 1'b0;
        idle_state("rst_mid_fill", 8'd0, 16'h0000);
        cyc(5);
        idle_state("rst_stays_idle", 8'd0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
